drac_port_arbiter: RTL and testbench
====================================

Name: drac_port_arbiter

Overview:
- Shares the single drac_ddr3 system port (srd/swr/sa/swdat/smsk/srdat/srdy) between NPORTS requesters, e.g. drac_wb_adapter and a future CPU line-fill or video-scanout engine.
- Placement: between the requesters and drac, in the ck150 domain.
- Arbitration: round-robin, one transaction in flight at a time.
- Watchdog: bounds the wait for srdy and reports an error to the requester on timeout.

Parameters:
- NPORTS, 2: number of requester ports; legal values 2..4.
- AW, 29: sa width, matching address bits [33:5].
- DW, 256: data width per transaction.
- MW, 32: byte-mask width (DW/8).
- TIMEOUT, 1023: cycles to wait for srdy before aborting; 0 disables the watchdog.

Ports:
- clk  in  1  system clock (ck150).
- nrst  in  1  asynchronous active-low reset.
- p_srd  in  NPORTS  per-port read request.
- p_swr  in  NPORTS  per-port write request.
- p_sa  in  NPORTS*AW  per-port address; port k occupies [k*AW +: AW].
- p_swdat  in  NPORTS*DW  per-port write data.
- p_smsk  in  NPORTS*MW  per-port byte mask.
- p_srdat  out  DW  read data, broadcast to all ports.
- p_srdy  out  NPORTS  per-port completion strobe.
- p_err  out  NPORTS  per-port timeout strobe.
- drac_srd  out  1  read strobe to drac.
- drac_swr  out  1  write strobe to drac.
- drac_sa  out  AW  address to drac.
- drac_swdat  out  DW  write data to drac.
- drac_smsk  out  MW  byte mask to drac.
- drac_srdat  in  DW  read data from drac.
- drac_srdy  in  1  completion strobe from drac; one-cycle pulse, srdat valid in the same cycle.

Behaviour:
- Reset (asynchronous, nrst=0):
  - State IDLE; rr pointer = 0; grant = 0; watchdog = 0.
  - All drac_* outputs 0; p_srdy = 0; p_err = 0.
  - Deasserting nrst mid-transaction drops drac strobes immediately; the in-flight transaction is abandoned and no p_srdy is issued.
- Requester protocol:
  - Assert p_srd or p_swr with address, data and mask stable, and hold until p_srdy or p_err.
  - If p_swr and p_srd are both set on one port, the write is forwarded and the read is suppressed.
- States:
  - IDLE:
    - A port requests if p_srd[k] | p_swr[k].
    - If any port requests, the winner is the first requesting port at or after rr+1 (mod NPORTS). For example, with rr=0 and ports 0 and 1 both requesting, port 1 wins.
    - Register grant=winner and go to BUSY.
    - No request: stay in IDLE.
  - BUSY:
    - drac_srd/drac_swr/drac_sa/drac_swdat/drac_smsk are registered copies of the granted port's inputs, captured on IDLE->BUSY and held constant throughout BUSY.
    - Latency: a request seen in IDLE at cycle N gives drac strobes high at N+1.
    - On drac_srdy=1: p_srdy[grant] pulses in the same cycle (combinational); p_srdat = drac_srdat; rr = grant; go to RECOVER.
    - Watchdog increments each BUSY cycle. If TIMEOUT != 0 and the count reaches TIMEOUT without srdy: pulse p_err[grant] for one cycle, rr = grant, go to RECOVER.
  - RECOVER:
    - One cycle with drac strobes = 0, so drac sees a deassert between transactions.
    - Watchdog cleared; go to IDLE.
- Timing and data:
  - Back-to-back throughput: one transaction per (drac latency + 2) cycles.
  - p_srdat is driven as drac_srdat at all times; it is valid only when p_srdy pulses.
- Boundary cases:
  - A requester dropping its request during BUSY does not abort the transaction; it completes and the srdy is still pulsed to that port.
  - drac_srdy outside BUSY is ignored.
  - drac_srdy in the same cycle as the timeout: the completion wins; p_srdy pulses and p_err does not.
  - rr wraps from NPORTS-1 to 0.

Optional Feature:
- Macro: DRAC_ARB_STATS_EN.
- When defined, adds output grant_cnt (NPORTS*16 bits):
  - Per-port 16-bit counter of completed transactions.
  - Increments on each p_srdy; saturates at 16'hFFFF.
  - Cleared by nrst.
- When undefined: the port and counters are absent; all other behaviour is identical.

Test Plan:
- Single read on port 0, sa=29'h0000123, drac srdy 5 cycles after drac_srd rises -> drac_srd high at N+1; drac_sa=29'h0000123; p_srdy[0] pulses for one cycle with p_srdat=drac_srdat; one RECOVER cycle with strobes low.
- Ports 0 and 1 request continuously from reset -> grant order 1,0,1,0; no port is granted twice in a row while the other is requesting.
- Port 1 asserts p_srd and p_swr together with smsk=32'h0000000F -> only drac_swr is asserted; drac_smsk=32'h0000000F.
- TIMEOUT=16, drac never returns srdy -> p_err[grant] pulses 16 cycles into BUSY, followed by one RECOVER cycle; the other port is then serviced normally.
- nrst pulsed low mid-BUSY -> drac_srd/drac_swr drop asynchronously; no p_srdy is issued; after reset, port 1 wins the first simultaneous request (rr=0).
- With DRAC_ARB_STATS_EN defined, 3 completed transactions on port 0 -> grant_cnt[15:0]=3, grant_cnt[31:16]=0.

Source files
------------

// File: rtl/drac_port_arbiter.sv
// Round-robin arbiter sharing the single drac system port between NPORTS requesters,
// one transaction in flight, with a srdy watchdog. Optional stats: DRAC_ARB_STATS_EN.
module drac_port_arbiter #(
    parameter int NPORTS  = 2,
    parameter int AW      = 29,
    parameter int DW      = 256,
    parameter int MW      = 32,
    parameter int TIMEOUT = 1023
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic [NPORTS-1:0]    p_srd,
    input  logic [NPORTS-1:0]    p_swr,
    input  logic [NPORTS*AW-1:0] p_sa,
    input  logic [NPORTS*DW-1:0] p_swdat,
    input  logic [NPORTS*MW-1:0] p_smsk,
    output logic [DW-1:0]        p_srdat,
    output logic [NPORTS-1:0]    p_srdy,
    output logic [NPORTS-1:0]    p_err,
    output logic                 drac_srd,
    output logic                 drac_swr,
    output logic [AW-1:0]        drac_sa,
    output logic [DW-1:0]        drac_swdat,
    output logic [MW-1:0]        drac_smsk,
    input  logic [DW-1:0]        drac_srdat,
    input  logic                 drac_srdy
`ifdef DRAC_ARB_STATS_EN
    ,
    output logic [NPORTS*16-1:0] grant_cnt
`endif
);

    localparam int PW  = (NPORTS > 2) ? 2 : 1;
    localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, RECOVER} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   rr_q, rr_d;
    logic [PW-1:0]   grant_q, grant_d;
    logic [WDW-1:0]  wdog_q, wdog_d;
    logic            srd_q, srd_d;
    logic            swr_q, swr_d;
    logic [AW-1:0]   sa_q, sa_d;
    logic [DW-1:0]   swdat_q, swdat_d;
    logic [MW-1:0]   smsk_q, smsk_d;

    logic [NPORTS-1:0] req;
    logic [AW-1:0]     sa_arr    [NPORTS];
    logic [DW-1:0]     swdat_arr [NPORTS];
    logic [MW-1:0]     smsk_arr  [NPORTS];
    logic [PW-1:0]     winner;
    logic [PW-1:0]     idx;
    logic              found;
    logic              timeout_hit;

    genvar gi;
    generate
        for (gi = 0; gi < NPORTS; gi++) begin : g_port
            assign req[gi]       = p_srd[gi] | p_swr[gi];
            assign sa_arr[gi]    = p_sa[gi*AW +: AW];
            assign swdat_arr[gi] = p_swdat[gi*DW +: DW];
            assign smsk_arr[gi]  = p_smsk[gi*MW +: MW];
        end
        if (TIMEOUT != 0) begin : g_wdog
            assign timeout_hit = (wdog_q == WDW'(TIMEOUT - 1));
        end else begin : g_no_wdog
            assign timeout_hit = 1'b0;
        end
    endgenerate

    // Scan starts one past the last served port so nobody is granted twice while others wait.
    always_comb begin
        winner = rr_q;
        found  = 1'b0;
        idx    = '0;
        for (int i = 1; i <= NPORTS; i++) begin
            idx = PW'((int'(rr_q) + i) % NPORTS);
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        grant_d = grant_q;
        wdog_d  = wdog_q;
        srd_d   = srd_q;
        swr_d   = swr_q;
        sa_d    = sa_q;
        swdat_d = swdat_q;
        smsk_d  = smsk_q;
        p_srdy  = '0;
        p_err   = '0;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = winner;
                    swr_d   = p_swr[winner];
                    srd_d   = p_srd[winner] & ~p_swr[winner];
                    sa_d    = sa_arr[winner];
                    swdat_d = swdat_arr[winner];
                    smsk_d  = smsk_arr[winner];
                    wdog_d  = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                wdog_d = wdog_q + WDW'(1);
                // A completion arriving on the timeout cycle still counts as a completion.
                if (drac_srdy) begin
                    p_srdy[grant_q] = 1'b1;
                    rr_d    = grant_q;
                    srd_d   = 1'b0;
                    swr_d   = 1'b0;
                    state_d = RECOVER;
                end else if (timeout_hit) begin
                    p_err[grant_q] = 1'b1;
                    rr_d    = grant_q;
                    srd_d   = 1'b0;
                    swr_d   = 1'b0;
                    state_d = RECOVER;
                end
            end
            RECOVER: begin
                wdog_d  = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            rr_q    <= '0;
            grant_q <= '0;
            wdog_q  <= '0;
            srd_q   <= 1'b0;
            swr_q   <= 1'b0;
            sa_q    <= '0;
            swdat_q <= '0;
            smsk_q  <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            wdog_q  <= wdog_d;
            srd_q   <= srd_d;
            swr_q   <= swr_d;
            sa_q    <= sa_d;
            swdat_q <= swdat_d;
            smsk_q  <= smsk_d;
        end
    end

    assign drac_srd   = srd_q;
    assign drac_swr   = swr_q;
    assign drac_sa    = sa_q;
    assign drac_swdat = swdat_q;
    assign drac_smsk  = smsk_q;
    assign p_srdat    = drac_srdat;

`ifdef DRAC_ARB_STATS_EN
    generate
        for (gi = 0; gi < NPORTS; gi++) begin : g_stats
            logic [15:0] cnt_q, cnt_d;
            always_comb begin
                cnt_d = cnt_q;
                if (p_srdy[gi] && cnt_q != 16'hFFFF) begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            always_ff @(posedge clk or negedge nrst) begin
                if (!nrst) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end
            assign grant_cnt[gi*16 +: 16] = cnt_q;
        end
    endgenerate
`endif

endmodule

// File: tb/tb_drac_port_arbiter.sv
// Self-checking bench for drac_port_arbiter: transaction-level reference model compared
// every cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_drac_port_arbiter;
    localparam int NP = 2;
    localparam int AW = 29;
    localparam int DW = 256;
    localparam int MW = 32;
    localparam int TO = 16;

    logic               clk = 1'b0;
    logic               nrst;
    logic [NP-1:0]      p_srd, p_swr;
    logic [NP*AW-1:0]   p_sa;
    logic [NP*DW-1:0]   p_swdat;
    logic [NP*MW-1:0]   p_smsk;
    logic [DW-1:0]      p_srdat;
    logic [NP-1:0]      p_srdy, p_err;
    logic               drac_srd, drac_swr;
    logic [AW-1:0]      drac_sa;
    logic [DW-1:0]      drac_swdat;
    logic [MW-1:0]      drac_smsk;
    logic [DW-1:0]      drac_srdat;
    logic               drac_srdy;
`ifdef DRAC_ARB_STATS_EN
    logic [NP*16-1:0]   grant_cnt;
`endif

    always #5 clk = ~clk;

    drac_port_arbiter #(.NPORTS(NP), .AW(AW), .DW(DW), .MW(MW), .TIMEOUT(TO)) dut (
        .clk(clk), .nrst(nrst),
        .p_srd(p_srd), .p_swr(p_swr), .p_sa(p_sa), .p_swdat(p_swdat), .p_smsk(p_smsk),
        .p_srdat(p_srdat), .p_srdy(p_srdy), .p_err(p_err),
        .drac_srd(drac_srd), .drac_swr(drac_swr), .drac_sa(drac_sa),
        .drac_swdat(drac_swdat), .drac_smsk(drac_smsk),
        .drac_srdat(drac_srdat), .drac_srdy(drac_srdy)
`ifdef DRAC_ARB_STATS_EN
        , .grant_cnt(grant_cnt)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: is a transaction outstanding, is the bus resting, who owns it, how long so far.
    bit             m_busy, m_rec;
    int             m_rr, m_grant, m_waited;
    logic           m_srd, m_swr;
    logic [AW-1:0]  m_sa;
    logic [DW-1:0]  m_swdat;
    logic [MW-1:0]  m_smsk;
    int             m_done [NP];

    // drac responder knobs
    int  r_cnt = 0;
    int  r_lat = 5;
    bit  r_en = 1'b1, r_spur = 1'b0, r_rand = 1'b0;

    logic [NP-1:0] o_srdy, o_err;
    int            grant_log [$];
    bit            req_act [NP];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd_dw();
        logic [DW-1:0] v;
        for (int i = 0; i < DW/32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic model_cycle();
        logic [NP-1:0] e_srdy, e_err;
        if (!nrst) begin
            m_busy = 0; m_rec = 0; m_rr = 0; m_grant = 0; m_waited = 0;
            m_srd = 0; m_swr = 0; m_sa = '0; m_swdat = '0; m_smsk = '0;
            for (int k = 0; k < NP; k++) m_done[k] = 0;
        end
        e_srdy = '0;
        e_err  = '0;
        if (m_busy) begin
            if (drac_srdy) e_srdy[m_grant] = 1'b1;
            else if (m_waited + 1 == TO) e_err[m_grant] = 1'b1;
        end
        chk("drac_srd", drac_srd, m_busy & m_srd);
        chk("drac_swr", drac_swr, m_busy & m_swr);
        if (m_busy || !nrst) begin
            chk("drac_sa", drac_sa, m_sa);
            chk("drac_swdat", drac_swdat, m_swdat);
            chk("drac_smsk", drac_smsk, m_smsk);
        end
        chk("p_srdy", p_srdy, e_srdy);
        chk("p_err", p_err, e_err);
        chk("p_srdat", p_srdat, drac_srdat);
`ifdef DRAC_ARB_STATS_EN
        for (int k = 0; k < NP; k++) chk("grant_cnt", grant_cnt[k*16 +: 16], m_done[k]);
`endif
        o_srdy = p_srdy;
        o_err  = p_err;
        for (int k = 0; k < NP; k++) if (p_srdy[k]) grant_log.push_back(k);
        if (nrst) begin
            if (m_rec) begin
                m_rec = 0;
            end else if (m_busy) begin
                if (drac_srdy) begin
                    m_busy = 0; m_rec = 1; m_rr = m_grant;
                    if (m_done[m_grant] < 16'hFFFF) m_done[m_grant]++;
                end else if (m_waited + 1 == TO) begin
                    m_busy = 0; m_rec = 1; m_rr = m_grant;
                end else begin
                    m_waited++;
                end
            end else begin
                for (int i = 1; i <= NP; i++) begin
                    int k;
                    k = (m_rr + i) % NP;
                    if (p_srd[k] | p_swr[k]) begin
                        m_busy = 1; m_waited = 0; m_grant = k;
                        m_swr = p_swr[k];
                        m_srd = p_srd[k] & ~p_swr[k];
                        m_sa = p_sa[k*AW +: AW];
                        m_swdat = p_swdat[k*DW +: DW];
                        m_smsk = p_smsk[k*MW +: MW];
                        break;
                    end
                end
            end
        end
    endtask

    // First half of a cycle: just after the rising edge, the drac responder acts.
    task automatic cyc_start();
        @(posedge clk);
        #1;
        drac_srdy  = 1'b0;
        drac_srdat = rnd_dw();
        if (drac_srd | drac_swr) begin
            r_cnt++;
            if (r_en && r_cnt == r_lat) drac_srdy = 1'b1;
        end else begin
            r_cnt = 0;
            if (r_spur && $urandom_range(0, 7) == 0) drac_srdy = 1'b1;
            if (r_rand) r_lat = $urandom_range(1, 20);
        end
    endtask

    task automatic cyc_end();
        @(negedge clk);
        model_cycle();
    endtask

    task automatic step();
        cyc_start();
        cyc_end();
    endtask

    task automatic set_req(input int k, input bit rd, input bit wr, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [MW-1:0] m);
        p_srd[k] = rd;
        p_swr[k] = wr;
        p_sa[k*AW +: AW] = a;
        p_swdat[k*DW +: DW] = d;
        p_smsk[k*MW +: MW] = m;
    endtask

    task automatic clear_reqs();
        p_srd = '0;
        p_swr = '0;
        for (int k = 0; k < NP; k++) req_act[k] = 1'b0;
    endtask

    task automatic do_reset();
        cyc_start();
        nrst = 1'b0;
        clear_reqs();
        cyc_end();
        step();
        cyc_start();
        nrst = 1'b1;
        cyc_end();
    endtask

    task automatic drive_reqs();
        for (int k = 0; k < NP; k++) begin
            if (req_act[k]) begin
                if (o_srdy[k] || o_err[k] || $urandom_range(0, 63) == 0) begin
                    p_srd[k] = 1'b0;
                    p_swr[k] = 1'b0;
                    req_act[k] = 1'b0;
                end
            end else if ($urandom_range(0, 3) == 0) begin
                int op;
                op = $urandom_range(0, 2);
                set_req(k, op != 1, op != 0, AW'($urandom), rnd_dw(), MW'($urandom));
                req_act[k] = 1'b1;
            end
        end
    endtask

    initial begin
        int t, busy;
        nrst = 1'b0;
        p_srd = '0; p_swr = '0; p_sa = '0; p_swdat = '0; p_smsk = '0;
        drac_srdy = 1'b0; drac_srdat = '0;
        o_srdy = '0; o_err = '0;
        for (int k = 0; k < NP; k++) req_act[k] = 1'b0;
        step();
        step();
        chk("reset_srd", drac_srd, 1'b0);
        chk("reset_srdy", p_srdy, 2'b00);
        cyc_start();
        nrst = 1'b1;
        cyc_end();

        // Single read on port 0, srdy in the 5th BUSY cycle
        r_en = 1; r_lat = 5; r_rand = 0; r_spur = 0;
        cyc_start();
        set_req(0, 1, 0, 29'h0000123, rnd_dw(), 32'hFFFFFFFF);
        cyc_end();
        step();
        chk("t1_srd_n1", drac_srd, 1'b1);
        chk("t1_sa", drac_sa, 29'h0000123);
        busy = 1; t = 0;
        while (!o_srdy[0] && t < 40) begin step(); t++; busy += drac_srd; end
        chk("t1_busy_cycles", busy, 5);
        cyc_start();
        clear_reqs();
        cyc_end();
        chk("t1_recover_srd", drac_srd, 1'b0);
        chk("t1_recover_srdy", p_srdy, 2'b00);
        step();

        // Both ports requesting continuously from reset: strict alternation starting at 1
        do_reset();
        r_lat = 3;
        cyc_start();
        set_req(0, 1, 0, 29'h1111, rnd_dw(), 32'h1);
        set_req(1, 0, 1, 29'h2222, rnd_dw(), 32'h2);
        cyc_end();
        grant_log.delete();
        t = 0;
        while (grant_log.size() < 4 && t < 200) begin step(); t++; end
        chk("t2_bound", grant_log.size(), 4);
        if (grant_log.size() >= 4) begin
            chk("t2_grant0", grant_log[0], 1);
            chk("t2_grant1", grant_log[1], 0);
            chk("t2_grant2", grant_log[2], 1);
            chk("t2_grant3", grant_log[3], 0);
        end
        cyc_start();
        clear_reqs();
        cyc_end();
        step(); step(); step(); step(); step(); step();

        // Port 1 read+write together: only the write goes out
        cyc_start();
        set_req(1, 1, 1, 29'h0ABCDEF, rnd_dw(), 32'h0000000F);
        cyc_end();
        step();
        chk("t3_swr", drac_swr, 1'b1);
        chk("t3_srd", drac_srd, 1'b0);
        chk("t3_smsk", drac_smsk, 32'h0000000F);
        t = 0;
        while (!o_srdy[1] && t < 40) begin step(); t++; end
        chk("t3_done", o_srdy, 2'b10);
        cyc_start();
        clear_reqs();
        cyc_end();
        step();

        // Watchdog: drac never answers port 0, then port 1 is served normally
        r_en = 0;
        cyc_start();
        set_req(0, 1, 0, 29'h0000777, rnd_dw(), 32'h0);
        cyc_end();
        t = 0; busy = 0;
        while (!o_err[0] && t < 60) begin step(); t++; busy += drac_srd; end
        chk("t4_busy_cycles", busy, 16);
        chk("t4_err", o_err, 2'b01);
        cyc_start();
        clear_reqs();
        set_req(1, 1, 0, 29'h0000888, rnd_dw(), 32'h0);
        r_en = 1; r_lat = 2;
        cyc_end();
        chk("t4_recover_srd", drac_srd, 1'b0);
        t = 0;
        while (!o_srdy[1] && t < 40) begin step(); t++; end
        chk("t4_port1_done", o_srdy, 2'b10);
        cyc_start();
        clear_reqs();
        cyc_end();
        step();

        // Asynchronous reset in the middle of a transaction
        r_lat = 10;
        cyc_start();
        set_req(0, 1, 0, 29'h0000999, rnd_dw(), 32'h0);
        cyc_end();
        step(); step(); step();
        chk("t5_busy", drac_srd, 1'b1);
        #2;
        nrst = 1'b0;
        #1;
        chk("t5_async_drop", drac_srd, 1'b0);
        chk("t5_no_srdy", p_srdy, 2'b00);
        cyc_start();
        clear_reqs();
        cyc_end();
        step();
        cyc_start();
        nrst = 1'b1;
        r_lat = 2;
        set_req(0, 1, 0, 29'h0000AAA, rnd_dw(), 32'h0);
        set_req(1, 1, 0, 29'h0000BBB, rnd_dw(), 32'h0);
        cyc_end();
        grant_log.delete();
        t = 0;
        while (grant_log.size() < 1 && t < 40) begin step(); t++; end
        chk("t5_bound", grant_log.size(), 1);
        if (grant_log.size() >= 1) chk("t5_first_grant", grant_log[0], 1);
        cyc_start();
        clear_reqs();
        cyc_end();
        step();

        // Randomized traffic with random drac latency (incl. timeouts and ties) and stray srdy
        r_rand = 1; r_spur = 1; r_en = 1;
        for (int c = 0; c < 3000; c++) begin
            cyc_start();
            drive_reqs();
            cyc_end();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
